// File: rtl/processor_param_pkg.sv
// Shared definitions for the parametrised multicycle register-file processor:
// opcodes, FSM state encoding and instruction-width helper.
package processor_param_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_T1    = 2'd1,
        ST_T2    = 2'd2,
        ST_T3    = 2'd3
    } state_t;

    // {opcode[2:0], rx, ry}
    function automatic int instr_width(input int rsel);
        return 32'd3 + 32'd2 * rsel;
    endfunction

endpackage

// File: rtl/processor_param_if.sv
// Instruction handshake and observation bundle between the instruction source
// (master) and the processor (slave).
interface processor_param_if
    import processor_param_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int RSEL = $clog2(NREGS);
    localparam int IW   = instr_width(RSEL);

    logic [IW-1:0]          instr;
    logic [WIDTH-1:0]       imm;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   done;
    logic                   zero;
    logic                   carry;
    logic [WIDTH-1:0]       bus;
    logic [NREGS*WIDTH-1:0] regs;
    logic [1:0]             state;

    modport master (
        output instr, imm, instr_valid,
        input  instr_ready, done, zero, carry, bus, regs, state
    );

    modport slave (
        input  instr, imm, instr_valid,
        output instr_ready, done, zero, carry, bus, regs, state
    );

endinterface

// File: rtl/processor_param_alu.sv
// Combinational ALU: add/inc, subtract with borrow, xor, and; zero flag on result.
module processor_param_alu
    import processor_param_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    logic [WIDTH:0] wide_s;

    // Operation select; the extra top bit of wide_s is carry-out or borrow
    always_comb begin
        wide_s = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD, OP_INC: wide_s = {1'b0, a} + {1'b0, b};
            OP_SUB:         wide_s = {1'b0, a} - {1'b0, b};
            OP_XOR:         wide_s = {1'b0, a ^ b};
            OP_AND:         wide_s = {1'b0, a & b};
            default:        wide_s = {(WIDTH+1){1'b0}};
        endcase
        result = wide_s[WIDTH-1:0];
        carry  = wide_s[WIDTH];
        zero   = (wide_s[WIDTH-1:0] == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/processor_param.sv
// Multicycle register-file processor: FETCH handshake, then one cycle for moves
// or three cycles (A load, G compute, writeback) for ALU operations.
module processor_param
    import processor_param_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic           clock,
    input  logic           reset,
    processor_param_if.slave pif
);

    localparam int RSEL = $clog2(NREGS);
    localparam int IW   = instr_width(RSEL);

    state_t            state_r, state_nxt_s;
    logic [2:0]        op_r;
    logic [RSEL-1:0]   rx_r, ry_r;
    logic [WIDTH-1:0]  imm_r, a_r, g_r;
    logic [WIDTH-1:0]  regs_r [NREGS];
    logic              zero_r, carry_r;
    logic [WIDTH-1:0]  bus_s, alu_res_s;
    logic              alu_zero_s, alu_carry_s;
    logic              done_s, ready_s, simple_s;

    processor_param_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_r),
        .b      (bus_s),
        .op     (op_r),
        .result (alu_res_s),
        .zero   (alu_zero_s),
        .carry  (alu_carry_s)
    );

    // Bus mux driven purely from state, IR and register contents
    always_comb begin
        bus_s = {WIDTH{1'b0}};
        case (state_r)
            ST_FETCH: bus_s = {WIDTH{1'b0}};
            ST_T1: begin
                case (op_r)
                    OP_MV:   bus_s = regs_r[ry_r];
                    OP_MVI:  bus_s = imm_r;
                    OP_NOP:  bus_s = {WIDTH{1'b0}};
                    default: bus_s = regs_r[rx_r];
                endcase
            end
            ST_T2: begin
                if (op_r == OP_INC) begin
                    bus_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    bus_s = regs_r[ry_r];
                end
            end
            ST_T3:    bus_s = g_r;
            default:  bus_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic with handshake ready and completion pulse
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        done_s      = 1'b0;
        simple_s    = (op_r == OP_MV) || (op_r == OP_MVI) || (op_r == OP_NOP);
        case (state_r)
            ST_FETCH: begin
                ready_s = 1'b1;
                if (pif.instr_valid) begin
                    state_nxt_s = ST_T1;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_T1: begin
                if (simple_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_T2;
                end
            end
            ST_T2: state_nxt_s = ST_T3;
            ST_T3: begin
                done_s      = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Architectural state: IR, register file, A, G and flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
            op_r    <= 3'b000;
            rx_r    <= {RSEL{1'b0}};
            ry_r    <= {RSEL{1'b0}};
            imm_r   <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            g_r     <= {WIDTH{1'b0}};
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_FETCH: begin
                    if (pif.instr_valid) begin
                        op_r  <= pif.instr[IW-1 -: 3];
                        rx_r  <= pif.instr[2*RSEL-1 -: RSEL];
                        ry_r  <= pif.instr[RSEL-1:0];
                        imm_r <= pif.imm;
                    end
                end
                ST_T1: begin
                    if ((op_r == OP_MV) || (op_r == OP_MVI)) begin
                        regs_r[rx_r] <= bus_s;
                    end else if (op_r != OP_NOP) begin
                        a_r <= bus_s;
                    end
                end
                ST_T2: begin
                    g_r     <= alu_res_s;
                    zero_r  <= alu_zero_s;
                    carry_r <= alu_carry_s;
                end
                ST_T3:   regs_r[rx_r] <= g_r;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
        assign pif.regs[gi*WIDTH +: WIDTH] = regs_r[gi];
    end

    assign pif.instr_ready = ready_s;
    assign pif.done        = done_s;
    assign pif.bus         = bus_s;
    assign pif.zero        = zero_r;
    assign pif.carry       = carry_r;
    assign pif.state       = state_r;

endmodule

// File: tb/tb_processor_param.sv
// Scoreboard bench for processor_param: a 16-bit/8-register instance driven
// through a reference model, plus an 8-bit/4-register instance.
module tb_processor_param;
    import processor_param_pkg::*;

    typedef struct {
        int           lat;
        logic [15:0]  bus;
        logic [127:0] regs;
        logic         z;
        logic         c;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    exp_t        sb[$];
    logic [15:0] m[8];
    logic        mz, mc;

    processor_param_if #(.WIDTH(16), .NREGS(8)) pif ();
    processor_param_if #(.WIDTH(8),  .NREGS(4)) p2 ();

    processor_param #(.WIDTH(16), .NREGS(8)) dut (
        .clock (clock),
        .reset (reset),
        .pif   (pif)
    );

    processor_param #(.WIDTH(8), .NREGS(4)) dut2 (
        .clock (clock),
        .reset (reset),
        .pif   (p2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] flat();
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = m[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    task automatic exec(input logic [2:0] op, input int rx, input int ry,
                        input logic [15:0] im, input bit noise);
        exp_t        e;
        int          cyc;
        logic [16:0] w;
        logic [15:0] res;
        @(negedge clock);
        pif.instr       = {op, 3'(rx), 3'(ry)};
        pif.imm         = im;
        pif.instr_valid = 1'b1;
        cyc = 0;
        while (!pif.instr_ready && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        chk("ready_fetch", pif.instr_ready, 1'b1);
        e.lat = 3;
        res   = 16'h0000;
        case (op)
            OP_MV:  begin res = m[ry]; e.lat = 1; end
            OP_MVI: begin res = im;    e.lat = 1; end
            OP_ADD: begin w = {1'b0, m[rx]} + {1'b0, m[ry]}; res = w[15:0]; mc = w[16]; end
            OP_SUB: begin w = {1'b0, m[rx]} - {1'b0, m[ry]}; res = w[15:0]; mc = w[16]; end
            OP_XOR: begin res = m[rx] ^ m[ry]; mc = 1'b0; end
            OP_AND: begin res = m[rx] & m[ry]; mc = 1'b0; end
            OP_INC: begin w = {1'b0, m[rx]} + 17'd1; res = w[15:0]; mc = w[16]; end
            default: begin res = 16'h0000; e.lat = 1; end
        endcase
        if (e.lat == 3) mz = (res == 16'h0000);
        if (op != OP_NOP) m[rx] = res;
        e.bus  = res;
        e.regs = flat();
        e.z    = mz;
        e.c    = mc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        pif.instr_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (noise && !pif.done) begin
                pif.instr_valid = 1'($urandom_range(1, 0));
                pif.instr       = {OP_MVI, 3'd7, 3'd0};
                pif.imm         = 16'hBEEF;
            end
        end while (!pif.done && cyc < 8);
        pif.instr_valid = 1'b0;
        e = sb.pop_front();
        chk("done_latency", cyc, e.lat);
        chk("bus_at_done", pif.bus, e.bus);
        @(posedge clock);
        #1;
        chk("regs", pif.regs, e.regs);
        chk("zero", pif.zero, e.z);
        chk("carry", pif.carry, e.c);
        chk("state_back", pif.state, 2'd0);
        chk("done_low", pif.done, 1'b0);
    endtask

    task automatic exec2(input logic [2:0] op, input logic [1:0] rx,
                         input logic [1:0] ry, input logic [7:0] im);
        int cyc;
        @(negedge clock);
        p2.instr       = {op, rx, ry};
        p2.imm         = im;
        p2.instr_valid = 1'b1;
        @(posedge clock);
        #1;
        p2.instr_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!p2.done && cyc < 8);
        chk("p2_done", p2.done, 1'b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        pif.instr = '0; pif.imm = '0; pif.instr_valid = 1'b0;
        p2.instr  = '0; p2.imm  = '0; p2.instr_valid  = 1'b0;
        reset = 1'b1;
        #17;
        chk("rst_ready", pif.instr_ready, 1'b1);
        chk("rst_done", pif.done, 1'b0);
        chk("rst_bus", pif.bus, 16'h0000);
        chk("rst_regs", pif.regs, 128'h0);
        chk("rst_state", pif.state, 2'd0);
        chk("rst_flags", {pif.zero, pif.carry}, 2'b00);
        @(negedge clock);
        reset = 1'b0;

        // SUB without and with borrow
        exec(OP_MVI, 1, 0, 16'h0005, 1'b0);
        exec(OP_MVI, 2, 0, 16'h0003, 1'b0);
        exec(OP_SUB, 1, 2, 16'h0000, 1'b0);
        exec(OP_MVI, 2, 0, 16'h0001, 1'b0);
        exec(OP_SUB, 2, 1, 16'h0000, 1'b0);

        // INC wraparound
        exec(OP_MVI, 3, 0, 16'hFFFF, 1'b0);
        exec(OP_INC, 3, 0, 16'h0000, 1'b0);

        // idle, then valid toggling during T1..T3
        repeat (5) @(negedge clock);
        chk("idle_state", pif.state, 2'd0);
        chk("idle_regs", pif.regs, flat());
        exec(OP_ADD, 1, 2, 16'h0000, 1'b1);
        exec(OP_MV, 6, 1, 16'h0000, 1'b1);

        // AND, XOR self, NOP, SUB self
        exec(OP_MVI, 4, 0, 16'h00F0, 1'b0);
        exec(OP_MVI, 5, 0, 16'h0FF0, 1'b0);
        exec(OP_AND, 4, 5, 16'h0000, 1'b0);
        exec(OP_XOR, 4, 4, 16'h0000, 1'b0);
        exec(OP_NOP, 5, 1, 16'h1234, 1'b0);
        exec(OP_SUB, 5, 5, 16'h0000, 1'b0);
        exec(OP_INC, 2, 0, 16'h0000, 1'b0);

        // reset in the middle of an ADD
        exec(OP_MVI, 3, 0, 16'hFFFF, 1'b0);
        exec(OP_INC, 3, 0, 16'h0000, 1'b0);
        exec(OP_MVI, 3, 0, 16'h8000, 1'b0);
        @(negedge clock);
        pif.instr       = {OP_ADD, 3'd3, 3'd3};
        pif.instr_valid = 1'b1;
        @(posedge clock);
        #1;
        pif.instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_state_t2", pif.state, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", pif.state, 2'd0);
        chk("mid_rst_regs", pif.regs, 128'h0);
        chk("mid_rst_flags", {pif.zero, pif.carry}, 2'b00);
        chk("mid_rst_ready", pif.instr_ready, 1'b1);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("post_rst_regs", pif.regs, 128'h0);
        exec(OP_MVI, 0, 0, 16'h00A5, 1'b0);

        // narrow instance
        chk("p2_iw", $bits(p2.instr), 7);
        exec2(OP_MVI, 2'd3, 2'd0, 8'h80);
        chk("p2_mvi", p2.regs[31:24], 8'h80);
        exec2(OP_ADD, 2'd3, 2'd3, 8'h00);
        chk("p2_add_r3", p2.regs[31:24], 8'h00);
        chk("p2_carry", p2.carry, 1'b1);
        chk("p2_zero", p2.zero, 1'b1);
        chk("p2_other_regs", p2.regs[23:0], 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
